// File: rtl/lcd_pkg.sv
// Shared constants for the HD44780 character-LCD writer: FSM encoding,
// the power-up command ROM and timing helpers.
package lcd_pkg;

  localparam logic [2:0] ST_PWRUP = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_EN_HI = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_WAIT  = 3'd4;
  localparam logic [2:0] ST_IDLE  = 3'd5;

  localparam logic [7:0] LCD_CMD_FUNC_SET_8B2L = 8'h38;
  localparam logic [7:0] LCD_CMD_DISP_ON       = 8'h0C;
  localparam logic [7:0] LCD_CMD_CLEAR         = 8'h01;
  localparam logic [7:0] LCD_CMD_ENTRY_INC     = 8'h06;
  localparam logic [7:0] LCD_CMD_SLOW_LAST     = 8'h03;

  localparam int INIT_LEN = 4;

  function automatic logic [7:0] init_rom(input logic [1:0] idx);
    logic [7:0] cmd;
    case (idx)
      2'd0:    cmd = LCD_CMD_FUNC_SET_8B2L;
      2'd1:    cmd = LCD_CMD_DISP_ON;
      2'd2:    cmd = LCD_CMD_CLEAR;
      default: cmd = LCD_CMD_ENTRY_INC;
    endcase
    return cmd;
  endfunction

  // Clear and return-home instructions need the long busy wait.
  function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data >= LCD_CMD_CLEAR) && (data <= LCD_CMD_SLOW_LAST);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// Loadable down-counter timing every phase of the LCD writer; done is high
// while the count sits at zero.
module lcd_delay_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         done
);

  logic [W-1:0] value_q;
  logic [W-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = load_value;
    end else if (value_q != '0) begin
      value_d = value_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign done = (value_q == '0);

endmodule

// File: rtl/lcd_hd44780_writer.sv
// Write-only HD44780 driver: runs the power-up init sequence, then forwards
// handshaked command/data bytes as correctly timed EN strobes.
module lcd_hd44780_writer
  import lcd_pkg::*;
#(
  parameter int unsigned T_PWRUP = 750000,
  parameter int unsigned T_SETUP = 2,
  parameter int unsigned T_EN    = 12,
  parameter int unsigned T_HOLD  = 1,
  parameter int unsigned T_EXEC  = 2000,
  parameter int unsigned T_CLEAR = 82000
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       wr_valid,
  input  logic       wr_rs,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  output logic       init_done,
  output logic [7:0] LCD_DATA,
  output logic       LCD_RW,
  output logic       LCD_RS,
  output logic       LCD_EN,
  output logic       LCD_ON,
  output logic       LCD_BLON
);

  localparam int unsigned T_MAX = max_u(max_u(max_u(T_PWRUP, T_SETUP), max_u(T_EN, T_HOLD)),
                                        max_u(T_EXEC, T_CLEAR));
  localparam int CNT_W = $clog2(T_MAX) + 1;

  // Phases are exact: loading N-1 gives N cycles before done is seen.
  function automatic logic [CNT_W-1:0] ticks(input int unsigned t);
    return CNT_W'(t - 1);
  endfunction

  logic [2:0]       state_q, state_d;
  logic [1:0]       init_idx_q, init_idx_d;
  logic             lcd_en_q, lcd_en_d;
  logic             lcd_rs_q, lcd_rs_d;
  logic [7:0]       lcd_data_q, lcd_data_d;
  logic             lcd_on_q, lcd_on_d;
  logic             lcd_blon_q, lcd_blon_d;
  logic             wr_ready_q, wr_ready_d;
  logic             init_done_q, init_done_d;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_value;
  logic             cnt_done;

  lcd_delay_counter #(
    .W(CNT_W)
  ) u_delay (
    .clk        (CLOCK_50),
    .rst_n      (RESET_N),
    .load       (cnt_load),
    .load_value (cnt_value),
    .done       (cnt_done)
  );

  always_comb begin
    state_d     = state_q;
    init_idx_d  = init_idx_q;
    lcd_en_d    = lcd_en_q;
    lcd_rs_d    = lcd_rs_q;
    lcd_data_d  = lcd_data_q;
    lcd_on_d    = lcd_on_q;
    lcd_blon_d  = lcd_blon_q;
    wr_ready_d  = wr_ready_q;
    init_done_d = init_done_q;
    cnt_load    = 1'b0;
    cnt_value   = '0;

    case (state_q)
      ST_PWRUP: begin
        // The first cycle out of reset powers the panel and starts the settle delay.
        if (!lcd_on_q) begin
          lcd_on_d   = 1'b1;
          lcd_blon_d = 1'b1;
          cnt_load   = 1'b1;
          cnt_value  = ticks(T_PWRUP);
        end else if (cnt_done) begin
          state_d    = ST_SETUP;
          lcd_rs_d   = 1'b0;
          lcd_data_d = init_rom(init_idx_q);
          cnt_load   = 1'b1;
          cnt_value  = ticks(T_SETUP);
        end
      end

      ST_SETUP: begin
        if (cnt_done) begin
          state_d   = ST_EN_HI;
          lcd_en_d  = 1'b1;
          cnt_load  = 1'b1;
          cnt_value = ticks(T_EN);
        end
      end

      ST_EN_HI: begin
        if (cnt_done) begin
          state_d   = ST_HOLD;
          lcd_en_d  = 1'b0;
          cnt_load  = 1'b1;
          cnt_value = ticks(T_HOLD);
        end
      end

      ST_HOLD: begin
        if (cnt_done) begin
          state_d   = ST_WAIT;
          cnt_load  = 1'b1;
          cnt_value = is_slow_cmd(lcd_rs_q, lcd_data_q) ? ticks(T_CLEAR) : ticks(T_EXEC);
        end
      end

      ST_WAIT: begin
        if (cnt_done) begin
          if (init_done_q || (init_idx_q == 2'(INIT_LEN - 1))) begin
            state_d     = ST_IDLE;
            wr_ready_d  = 1'b1;
            init_done_d = 1'b1;
          end else begin
            state_d    = ST_SETUP;
            init_idx_d = init_idx_q + 2'd1;
            lcd_rs_d   = 1'b0;
            lcd_data_d = init_rom(init_idx_q + 2'd1);
            cnt_load   = 1'b1;
            cnt_value  = ticks(T_SETUP);
          end
        end
      end

      ST_IDLE: begin
        if (wr_valid && wr_ready_q) begin
          state_d    = ST_SETUP;
          wr_ready_d = 1'b0;
          lcd_rs_d   = wr_rs;
          lcd_data_d = wr_data;
          cnt_load   = 1'b1;
          cnt_value  = ticks(T_SETUP);
        end
      end

      default: begin
        state_d    = ST_PWRUP;
        wr_ready_d = 1'b0;
        lcd_en_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_PWRUP;
      init_idx_q  <= 2'd0;
      lcd_en_q    <= 1'b0;
      lcd_rs_q    <= 1'b0;
      lcd_data_q  <= 8'h00;
      lcd_on_q    <= 1'b0;
      lcd_blon_q  <= 1'b0;
      wr_ready_q  <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_idx_q  <= init_idx_d;
      lcd_en_q    <= lcd_en_d;
      lcd_rs_q    <= lcd_rs_d;
      lcd_data_q  <= lcd_data_d;
      lcd_on_q    <= lcd_on_d;
      lcd_blon_q  <= lcd_blon_d;
      wr_ready_q  <= wr_ready_d;
      init_done_q <= init_done_d;
    end
  end

  assign wr_ready  = wr_ready_q;
  assign init_done = init_done_q;
  assign LCD_DATA  = lcd_data_q;
  assign LCD_RW    = 1'b0;
  assign LCD_RS    = lcd_rs_q;
  assign LCD_EN    = lcd_en_q;
  assign LCD_ON    = lcd_on_q;
  assign LCD_BLON  = lcd_blon_q;

endmodule
